i2c_target: RTL

I2C target (slave) with an internal 8 x 8-bit register bank and auto-incrementing register pointer. It is the responder-side counterpart to the EF_I2C_WB controller in the user project: it sits on the same SCL/SDA pads and lets the controller be exercised in loopback on silicon. It also serves as a standalone configuration-register target for an external I2C master.

---
 rtl/i2c_target.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target with an 8 x 8-bit register bank and an auto-incrementing register pointer.
// Pads are synchronized; every protocol decision uses the synchronized SCL/SDA.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen_o,
  output logic [63:0] regs_o,
  output logic        wr_o,
  output logic [2:0]  wr_addr_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic            oen_q, oen_d;
  logic            wr_q, wr_d;
  logic [2:0]      wr_addr_q, wr_addr_d;

  logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Stage [1] is the synchronized level, stage [2] its one-cycle-old copy.
  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_sync_q[2];
  assign scl_fall  = ~scl & scl_sync_q[2];
  assign start_det = scl & scl_sync_q[2] & sda_sync_q[2] & ~sda;
  assign stop_det  = scl & scl_sync_q[2] & ~sda_sync_q[2] & sda;
  assign rx_byte   = {shift_q[6:0], sda};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      regs_q     <= '0;
      oen_q      <= 1'b1;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      oen_q      <= oen_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    oen_d      = oen_q;
    wr_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oen_d   = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      oen_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, PTR, WDATA: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
            end else if (state_q == PTR) begin
              ptr_d   = rx_byte[2:0];
              state_d = PTR_ACK;
            end else begin
              regs_d[ptr_q] = rx_byte;
              wr_d          = 1'b1;
              wr_addr_d     = ptr_q;
              ptr_d         = ptr_q + 3'd1;
              state_d       = WDATA_ACK;
            end
          end
        end
        // First SCL fall of an ACK slot pulls SDA low, the second one ends the slot.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (oen_q) begin
            oen_d = 1'b0;
          end else if (state_q == ADDR_ACK && shift_q[0]) begin
            shift_d = regs_q[ptr_q];
            oen_d   = regs_q[ptr_q][7];
            ptr_d   = ptr_q + 3'd1;
            cnt_d   = '0;
            state_d = RDATA;
          end else begin
            oen_d   = 1'b1;
            state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
          end
        end
        // cnt counts bits already sampled by the controller; a fall at 0 follows a read ACK.
        RDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oen_d = shift_q[7];
            end else if (cnt_q == 4'd8) begin
              oen_d   = 1'b1;
              cnt_d   = '0;
              state_d = RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = shift_q[6];
            end
          end
        end
        RDATA_ACK: if (scl_rise) begin
          if (sda) begin
            state_d = IDLE;
          end else begin
            shift_d = regs_q[ptr_q];
            ptr_d   = ptr_q + 3'd1;
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // START/STOP release the bus in the very cycle they are detected.
  always_comb begin
    sda_o     = 1'b0;
    sda_oen_o = oen_q | start_det | stop_det;
    busy_o    = !(state_q inside {IDLE, ADDR});
    regs_o    = regs_q;
    wr_o      = wr_q;
    wr_addr_o = wr_addr_q;
  end

endmodule
